// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the shared memory port: instruction fetch (0) and load/store (1).
// One transaction in flight; write requests complete at grant, read requests wait for the response.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int PRIO_MODE  = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req0_i,
    input  logic                  req1_i,
    input  logic [ADDR_WIDTH-1:0] addr0_i,
    input  logic [ADDR_WIDTH-1:0] addr1_i,
    input  logic [DATA_WIDTH-1:0] wdata0_i,
    input  logic [DATA_WIDTH-1:0] wdata1_i,
    input  logic                  we0_i,
    input  logic                  we1_i,
    output logic                  gnt0_o,
    output logic                  gnt1_o,
    output logic                  rvalid0_o,
    output logic                  rvalid1_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  sel_o,
    output logic                  mem_valid_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    output logic                  mem_we_o,
    input  logic                  mem_ready_i,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_RESP
    } state_e;

    state_e state_q, state_d;
    logic   sel_q, sel_d;
    logic   lastGrant_q, lastGrant_d;
    logic   winner;

    // lastGrant resets to 1 so the very first tie goes to requester 0.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            sel_q       <= 1'b0;
            lastGrant_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            lastGrant_q <= lastGrant_d;
        end
    end

    always_comb begin
        winner = 1'b0;
        if (req0_i && req1_i) begin
            winner = (PRIO_MODE == 1) ? 1'b1 : ~lastGrant_q;
        end else if (req1_i) begin
            winner = 1'b1;
        end
    end

    // The mux select only moves on arbitration, so the shared port is quiet while idle or busy.
    assign mem_addr_o  = sel_q ? addr1_i  : addr0_i;
    assign mem_wdata_o = sel_q ? wdata1_i : wdata0_i;
    assign mem_we_o    = sel_q ? we1_i    : we0_i;
    assign sel_o       = sel_q;
    assign rdata_o     = mem_rdata_i;

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        lastGrant_d = lastGrant_q;
        gnt0_o      = 1'b0;
        gnt1_o      = 1'b0;
        rvalid0_o   = 1'b0;
        rvalid1_o   = 1'b0;
        mem_valid_o = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req0_i || req1_i) begin
                    sel_d   = winner;
                    state_d = REQ;
                end
            end
            REQ: begin
                mem_valid_o = 1'b1;
                if (mem_ready_i) begin
                    gnt0_o      = ~sel_q;
                    gnt1_o      = sel_q;
                    lastGrant_d = sel_q;
                    state_d     = mem_we_o ? IDLE : WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                if (mem_rvalid_i) begin
                    rvalid0_o = ~sel_q;
                    rvalid1_o = sel_q;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares the single memory port between instruction fetch (requester 0) and load/store (requester 1) in the central core. It arbitrates, drives the select of the general-purpose 2:1 mux steering address, write data and write-enable onto the shared port, and handles the port's valid/ready request handshake. It routes each read response back to its owner. One transaction is outstanding at a time.

## Interface
- ADDR_WIDTH, 64, address width of requesters and shared port
- DATA_WIDTH, 64, write/read data width
- PRIO_MODE, 0, 0 = round-robin; 1 = fixed priority, requester 1 always wins ties
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low; one clock, asynchronous active-low reset is fixed
- req0 / req1  in  1  requester N wants a transaction; held until its gnt
- addr0 / addr1  in  ADDR_WIDTH  request address, stable while reqN high
- wdata0 / wdata1  in  DATA_WIDTH  write data, stable while reqN high
- we0 / we1  in  1  1 = write, 0 = read, stable while reqN high
- gnt0 / gnt1  out  1  one-cycle pulse: port accepted requester N's transaction
- rvalid0 / rvalid1  out  1  one-cycle pulse: read data for requester N on rdata
- rdata  out  DATA_WIDTH  read data, passthrough of mem_rdata, shared by both requesters
- sel  out  1  mux select (0 = requester 0, 1 = requester 1), registered
- mem_valid  out  1  shared-port request valid
- mem_addr  out  ADDR_WIDTH  sel-muxed address
- mem_wdata  out  DATA_WIDTH  sel-muxed write data
- mem_we  out  1  sel-muxed write enable
- mem_ready  in  1  port accepts request this cycle when mem_valid high
- mem_rvalid  in  1  read response valid
- mem_rdata  in  DATA_WIDTH  read response data

## Operation
- FSM states: IDLE, REQ, WAIT_RESP. Reset state IDLE.
- IDLE, no req: stay. IDLE, any req: pick winner, load sel, go REQ.
- Winner rules:
  - Only one req high: that requester wins.
  - Both high, PRIO_MODE=0: the requester not in last_grant wins.
  - Both high, PRIO_MODE=1: requester 1 wins.
- REQ: mem_valid=1. mem_addr/mem_wdata/mem_we = requester[sel] fields via 2:1 muxes.
  - mem_ready=0: stay in REQ; request is never withdrawn.
  - mem_ready=1: pulse gnt[sel], update last_grant<=sel. Go WAIT_RESP if mem_we=0, else IDLE. Writes produce no response.
- WAIT_RESP: mem_valid=0. On mem_rvalid, pulse rvalid[sel] and go IDLE.
- mem_rvalid in IDLE or REQ: ignored, no rvalid pulse.
- sel holds its value outside arbitration, so the muxes do not toggle while busy or idle.
- reqN dropped before gntN is a protocol violation. The arbiter keeps presenting the transaction until mem_ready.
- Reset values: state IDLE, sel=0, last_grant=1 (first round-robin tie goes to requester 0). gnt0/1, rvalid0/1 and mem_valid are 0. mem_addr/mem_wdata/mem_we follow requester 0 inputs.
- Asynchronous reset mid-transaction: immediate return to IDLE and all strobes low. A response arriving after reset release is discarded.

## Timing
- Arbitration latency: req sampled high in IDLE at edge k gives mem_valid high from edge k+1.
- gnt and rvalid are combinational from state, sel and mem_ready/mem_rvalid; high for exactly one cycle each.
- Minimum read: 1 cycle arbitration + 1 cycle REQ with mem_ready=1 + ≥1 cycle WAIT_RESP. Gap to the next grant is one IDLE cycle.
- Minimum write: 2 cycles from req to gnt, then IDLE. The next arbitration occurs the cycle after gnt.
- Continuous demand from both requesters under PRIO_MODE=0 alternates grants 0,1,0,1…
- Under PRIO_MODE=1, requester 0 can starve; this is accepted.

## Test plan
- Reset: hold rst_n=0 with mem_rvalid=1 -> all gnt/rvalid/mem_valid 0, sel=0. Release, no req -> mem_valid stays 0.
- Single read: req0=1, addr0=0x1000, mem_ready=1, mem_rvalid 3 cycles later with mem_rdata=0xDEADBEEF -> mem_addr=0x1000, gnt0 one pulse, rvalid0 one pulse with rdata=0xDEADBEEF, gnt1/rvalid1 never.
- Write with stall: req1=1, we1=1, addr1=0x2008, wdata1=0x55, mem_ready low 4 cycles -> mem_valid/mem_addr/mem_wdata stable 4 cycles. gnt1 pulses on the cycle mem_ready=1, then FSM returns to IDLE with no rvalid.
- Round-robin fairness: PRIO_MODE=0, req0 and req1 held high across 6 reads -> grant order 0,1,0,1,0,1, sel matches each grant.
- Fixed priority: PRIO_MODE=1, both req high over 3 writes -> gnt1 three times. Drop req1 -> gnt0 next arbitration.
- Mid-transaction reset: assert rst_n=0 in WAIT_RESP, release, then drive mem_rvalid=1 -> no rvalid pulse, state IDLE.
